// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR multiply-accumulate sequencer.
// Optional overflow reporting in the top is enabled with FIR_OVF_EN.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } fir_state_t;

    localparam int DW_DEF       = 16;
    localparam int ACCW_DEF     = 32;
    localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: write at the pointer, read back by tap offset
// from the newest sample with wrap-around.
module fir_delay_line #(
    parameter int TAPS = 8,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [DW-1:0]           i_data,
    input  logic [$clog2(TAPS)-1:0] i_tap,
    output logic [DW-1:0]           o_data
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_X = (AW + 1)'(TAPS);
    localparam logic [AW:0]   OFS    = (AW + 1)'(TAPS - 1);

    logic [DW-1:0] r_mem [TAPS];
    logic [AW-1:0] r_wptr;
    logic [AW:0]   w_raw;
    logic [AW-1:0] w_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            for (int k = 0; k < TAPS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
        end
    end

    // Newest sample sits one slot behind the (already advanced) pointer.
    assign w_raw  = {1'b0, r_wptr} + OFS - {1'b0, i_tap};
    assign w_rd   = (w_raw >= TAPS_X) ? AW'(w_raw - TAPS_X) : AW'(w_raw);
    assign o_data = r_mem[w_rd];

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR MAC sequencer: one tap per cycle into a registered mul/add datapath.
// Define FIR_OVF_EN to add the out_ovf accumulator-wrap flag.
module fir_mac_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACCW-1:0]         out_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [DW-1:0]           coef_wdata,
    output logic                    coef_err,
    output logic [DW-1:0]           mul_a,
    output logic [DW-1:0]           mul_b,
    input  logic [ACCW-1:0]         mul_result,
    output logic [ACCW-1:0]         add_acc_in,
    output logic [ACCW-1:0]         add_mul_out,
    input  logic [ACCW-1:0]         add_acc_out
`ifdef FIR_OVF_EN
    ,
    output logic                    out_ovf
`endif
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
    localparam logic [AW-1:0] DRN_LAST = AW'(DRAIN_CYCLES - 1);
    localparam logic [AW:0]   TAPS_X   = (AW + 1)'(TAPS);

    fir_state_t r_state, w_next;

    logic [AW-1:0]   r_tap;
    logic [DW-1:0]   r_coef [TAPS];
    logic [ACCW-1:0] r_out_data;
    logic            r_coef_err;
    logic            r_first_d;
    logic            w_accept;
    logic            w_coef_ok;
    logic [DW-1:0]   w_x;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_coef_ok = coef_we && (r_state == IDLE)
                       && ({1'b0, coef_addr} < TAPS_X);

    fir_delay_line #(
        .TAPS (TAPS),
        .DW   (DW)
    ) u_dline (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_accept),
        .i_data (in_data),
        .i_tap  (r_tap),
        .o_data (w_x)
    );

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = MAC;
            end
            MAC: begin
                mul_a = w_x;
                mul_b = r_coef[r_tap];
                if (r_tap == TAP_LAST) w_next = DRAIN;
            end
            DRAIN: begin
                if (r_tap == DRN_LAST) w_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_tap doubles as the drain counter; it restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tap      <= '0;
            r_out_data <= '0;
            r_coef_err <= 1'b0;
            r_first_d  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tap      <= (r_state != w_next) ? '0 : r_tap + 1'b1;
            r_coef_err <= coef_we && !w_coef_ok;
            r_first_d  <= (r_state == MAC) && (r_tap == '0);
            if (r_state == DRAIN && r_tap == DRN_LAST) begin
                r_out_data <= add_acc_out;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
            end
        end else if (w_coef_ok) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    // Tap-0 product starts a fresh sum; later products add to the feedback.
    assign add_acc_in  = (r_first_d || r_state == IDLE) ? '0 : add_acc_out;
    assign add_mul_out = mul_result;
    assign out_data    = r_out_data;
    assign coef_err    = r_coef_err;

`ifdef FIR_OVF_EN
    logic            r_prod_d;
    logic            r_ovf;
    logic [ACCW-1:0] w_sum;

    assign w_sum = add_acc_in + add_mul_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod_d <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_prod_d <= (r_state == MAC);
            if (w_accept) begin
                r_ovf <= 1'b0;
            end else if (r_prod_d && (w_sum < add_acc_in)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed bench for fir_mac_ctrl (TAPS=4) with a registered mul/add model;
// a TAPS=5 instance covers the out-of-range coefficient address.
module tb_fir_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        coef_err;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_result, add_acc_in, add_mul_out, add_acc_out;

    logic        coef_we5 = 1'b0;
    logic [2:0]  coef_addr5 = '0;
    logic        in_ready5, out_valid5, coef_err5;
    logic [31:0] out_data5, add_acc_in5, add_mul_out5;
    logic [15:0] mul_a5, mul_b5;
`ifdef FIR_OVF_EN
    logic        out_ovf, out_ovf5;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc   = 0;

    logic [31:0] exp_v [5];
    logic [15:0] smp_v [5];
    logic [31:0] hold_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_ctrl #(.TAPS(4), .DW(16), .ACCW(32)) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .coef_we (coef_we), .coef_addr (coef_addr),
        .coef_wdata (coef_wdata), .coef_err (coef_err),
        .mul_a (mul_a), .mul_b (mul_b), .mul_result (mul_result),
        .add_acc_in (add_acc_in), .add_mul_out (add_mul_out),
        .add_acc_out (add_acc_out)
`ifdef FIR_OVF_EN
        , .out_ovf (out_ovf)
`endif
    );

    fir_mac_ctrl #(.TAPS(5), .DW(16), .ACCW(32)) dut5 (
        .clk (clk), .rst (rst),
        .in_valid (1'b0), .in_ready (in_ready5), .in_data (16'h0),
        .out_valid (out_valid5), .out_ready (1'b0), .out_data (out_data5),
        .coef_we (coef_we5), .coef_addr (coef_addr5),
        .coef_wdata (16'h1234), .coef_err (coef_err5),
        .mul_a (mul_a5), .mul_b (mul_b5), .mul_result (32'h0),
        .add_acc_in (add_acc_in5), .add_mul_out (add_mul_out5),
        .add_acc_out (32'h0)
`ifdef FIR_OVF_EN
        , .out_ovf (out_ovf5)
`endif
    );

    // Registered 16x16 multiplier and registered 32-bit adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_result  <= '0;
            add_acc_out <= '0;
        end else begin
            mul_result  <= 32'(mul_a) * 32'(mul_b);
            add_acc_out <= add_acc_in + add_mul_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wcoef(input logic [1:0] a, input logic [15:0] d);
        coef_addr  = a;
        coef_wdata = d;
        coef_we    = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0;
        chk("coef_err_ok", coef_err, 0);
    endtask

    task automatic send(input logic [15:0] d);
        chk("in_ready", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_acc    = cyc;
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_lat"}, 32'(cyc - t_acc + 1), 7);
        chk(tag, out_data, exp);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consumed", out_valid, 0);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_coef_err", coef_err, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_acc_in", add_acc_in, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) wcoef(2'(i), 16'(i + 1));

        // Impulse, with a stalled consumer on the first result.
        send(16'd1);
        wait_out("imp0", 32'd1);
        hold_d   = out_data;
        in_valid = 1'b1;
        in_data  = 16'h0055;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hold_d);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        consume();

        // Dropped coefficient write during MAC.
        send(16'd0);
        coef_addr  = 2'd3;
        coef_wdata = 16'h00AA;
        coef_we    = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0;
        chk("err_mac_pulse", coef_err, 1);
        @(posedge clk); #1;
        chk("err_mac_clear", coef_err, 0);
        wait_out("imp1", 32'd2);
        consume();

        exp_v[0] = 32'd3; exp_v[1] = 32'd4; exp_v[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            send(16'd0);
            wait_out($sformatf("imp%0d", i + 2), exp_v[i]);
            consume();
        end
        send(16'd5);
        wait_out("imp5", 32'd5);
        consume();

        // Out-of-range address on the 5-tap instance.
        coef_addr5 = 3'd5;
        coef_we5   = 1'b1;
        @(posedge clk); #1;
        coef_we5 = 1'b0;
        chk("err_addr_pulse", coef_err5, 1);
        @(posedge clk); #1;
        chk("err_addr_clear", coef_err5, 0);
        coef_addr5 = 3'd4;
        coef_we5   = 1'b1;
        @(posedge clk); #1;
        coef_we5 = 1'b0;
        chk("err_addr_ok", coef_err5, 0);

        // Reset in MAC cycle 2.
        send(16'd7);
        @(posedge clk); #1;
        chk("mac2_mul_b", mul_b, 2);
        rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_mul_a", mul_a, 0);
        chk("arst_mul_b", mul_b, 0);
        chk("arst_acc_in", add_acc_in, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) wcoef(2'(i), 16'(i + 1));
        send(16'd1);
        wait_out("post_rst0", 32'd1);
        consume();
        send(16'd0);
        wait_out("post_rst1", 32'd2);
        consume();

        // Full-scale accumulation wraps modulo 2^32.
        do_reset();
        for (int i = 0; i < 4; i++) wcoef(2'(i), 16'hFFFF);
        exp_v[0] = 32'hFFFE0001; exp_v[1] = 32'hFFFC0002;
        exp_v[2] = 32'hFFFA0003; exp_v[3] = 32'hFFF80004;
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF);
            wait_out($sformatf("wrap%0d", i), exp_v[i]);
`ifdef FIR_OVF_EN
            chk($sformatf("ovf%0d", i), out_ovf, (i >= 1) ? 32'd1 : 32'd0);
`endif
            consume();
        end

        // Moving sum across write-pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) wcoef(2'(i), 16'd1);
        smp_v[0] = 16'd5;  smp_v[1] = 16'd6;  smp_v[2] = 16'd7;
        smp_v[3] = 16'd8;  smp_v[4] = 16'd9;
        exp_v[0] = 32'd5;  exp_v[1] = 32'd11; exp_v[2] = 32'd18;
        exp_v[3] = 32'd26; exp_v[4] = 32'd30;
        for (int i = 0; i < 5; i++) begin
            send(smp_v[i]);
            wait_out($sformatf("msum%0d", i), exp_v[i]);
            consume();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
